// File: rtl/simd_arb_pkg.sv
// rtl/simd_arb_pkg.sv - shared types and widths for the SIMD issue arbiter
package simd_arb_pkg;

    localparam int SIMD_DW     = 68;
    localparam int SIMD_OPW    = 13;
    localparam int SIMD_TAG_W  = 9;
    localparam int SIMD_PORT_W = 2;

    typedef struct packed {
        logic [SIMD_OPW-1:0]   op;
        logic [SIMD_DW-1:0]    A;
        logic [SIMD_DW-1:0]    B;
        logic [SIMD_TAG_W-1:0] tag;
    } simd_req_t;

    typedef struct packed {
        logic                   vld;
        logic [SIMD_PORT_W-1:0] port;
        logic [SIMD_TAG_W-1:0]  tag;
    } simd_tagpipe_t;

    function automatic int wrap_add(int base, int off, int n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/simd_arb_rfifo.sv
// rtl/simd_arb_rfifo.sv - show-ahead result FIFO with synchronous clear
module simd_arb_rfifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/simd_issue_arb.sv
// rtl/simd_issue_arb.sv - SIMD issue arbiter and result sequencer; SIMD_ARB_RR_EN selects round-robin
module simd_issue_arb
    import simd_arb_pkg::*;
#(
    parameter int NREQ  = 3,
    parameter int TAG_W = 9,
    parameter int LAT   = 2,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(NREQ)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [NREQ-1:0]                req_vld,
    input  logic [NREQ-1:0][SIMD_OPW-1:0]  req_op,
    input  logic [NREQ-1:0][SIMD_DW-1:0]   req_A,
    input  logic [NREQ-1:0][SIMD_DW-1:0]   req_B,
    input  logic [NREQ-1:0][TAG_W-1:0]     req_tag,
    output logic [NREQ-1:0]                req_rdy,
    output logic                           simd_en,
    output logic [SIMD_OPW-1:0]            simd_op,
    output logic [SIMD_DW-1:0]             simd_A,
    output logic [SIMD_DW-1:0]             simd_B,
    input  logic [SIMD_DW-1:0]             simd_res,
    output logic                           res_vld,
    output logic [PW-1:0]                  res_port,
    output logic [TAG_W-1:0]               res_tag,
    output logic [SIMD_DW-1:0]             res_data,
    input  logic                           res_rdy
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int FW = PW + TAG_W + SIMD_DW;

    simd_req_t     req [NREQ];
    simd_tagpipe_t tp  [LAT+1];
    logic [CW-1:0] cnt;
    logic [PW-1:0] gnt_port;
    logic          found;
    logic          accept;
    logic          eligible;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [FW-1:0] fifo_head;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req[i] = '{op: req_op[i], A: req_A[i], B: req_B[i], tag: SIMD_TAG_W'(req_tag[i])};
        end
    end

    // cnt covers in-flight ops plus buffered results, so a grant always has a FIFO slot.
    assign eligible = ~flush & ~rst & (cnt < CW'(DEPTH));

`ifdef SIMD_ARB_RR_EN
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] cand;

    always_comb begin
        gnt_port = '0;
        found    = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PW'(wrap_add(int'(rr_ptr), k, NREQ));
            if (!found && req_vld[cand]) begin
                found    = 1'b1;
                gnt_port = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)         rr_ptr <= PW'(NREQ-1);
        else if (accept) rr_ptr <= gnt_port;
    end
`else
    always_comb begin
        gnt_port = '0;
        found    = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_vld[i]) begin
                found    = 1'b1;
                gnt_port = PW'(i);
            end
        end
    end
`endif

    assign accept = found & eligible;

    always_comb begin
        req_rdy = '0;
        if (accept) req_rdy[gnt_port] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            simd_en <= 1'b0;
            simd_op <= '0;
            simd_A  <= '0;
            simd_B  <= '0;
        end else begin
            simd_en <= accept;
            if (accept) begin
                simd_op <= req[gnt_port].op;
                simd_A  <= req[gnt_port].A;
                simd_B  <= req[gnt_port].B;
            end
        end
    end

    // The tail stage lines up with the cycle simd_res carries that op's result.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int s = 0; s <= LAT; s++) tp[s] <= '0;
        end else begin
            tp[0] <= '{vld: accept, port: SIMD_PORT_W'(gnt_port), tag: req[gnt_port].tag};
            for (int s = 1; s <= LAT; s++) tp[s] <= tp[s-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            cnt <= '0;
        end else begin
            case ({accept, fifo_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign fifo_push = tp[LAT].vld;
    assign fifo_pop  = res_vld & res_rdy & ~flush & ~rst;

    simd_arb_rfifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_rfifo (
        .clk       (clk),
        .clr       (rst | flush),
        .push      (fifo_push),
        .push_data ({tp[LAT].port[PW-1:0], TAG_W'(tp[LAT].tag), simd_res}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign res_vld = ~fifo_empty;
    assign {res_port, res_tag, res_data} = fifo_head;

    a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_simd_issue_arb.sv
// tb/tb_simd_issue_arb.sv - directed bench with a queue-based reference model
module tb_simd_issue_arb;
    import simd_arb_pkg::*;

    localparam int NREQ  = 3;
    localparam int TAG_W = 9;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;
    localparam int PW    = 2;

    logic                      clk     = 1'b0;
    logic                      rst     = 1'b1;
    logic                      flush   = 1'b0;
    logic [NREQ-1:0]           req_vld = '0;
    logic [NREQ-1:0][12:0]     req_op  = '0;
    logic [NREQ-1:0][67:0]     req_A   = '0;
    logic [NREQ-1:0][67:0]     req_B   = '0;
    logic [NREQ-1:0][TAG_W-1:0] req_tag = '0;
    logic [NREQ-1:0]           req_rdy;
    logic                      simd_en;
    logic [12:0]               simd_op;
    logic [67:0]               simd_A;
    logic [67:0]               simd_B;
    logic [67:0]               simd_res;
    logic                      res_vld;
    logic [PW-1:0]             res_port;
    logic [TAG_W-1:0]          res_tag;
    logic [67:0]               res_data;
    logic                      res_rdy = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    simd_issue_arb #(.NREQ(NREQ), .TAG_W(TAG_W), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_vld(req_vld), .req_op(req_op), .req_A(req_A), .req_B(req_B), .req_tag(req_tag),
        .req_rdy(req_rdy),
        .simd_en(simd_en), .simd_op(simd_op), .simd_A(simd_A), .simd_B(simd_B),
        .simd_res(simd_res),
        .res_vld(res_vld), .res_port(res_port), .res_tag(res_tag), .res_data(res_data),
        .res_rdy(res_rdy)
    );

    function automatic logic [67:0] dp_fn(logic [12:0] op, logic [67:0] a, logic [67:0] b);
        return (a + b) ^ {55'd0, op};
    endfunction

    // Datapath stand-in: result appears on simd_res LAT cycles after simd_en.
    logic [67:0] dp_pipe [LAT];
    always @(posedge clk) begin
        dp_pipe[0] <= simd_en ? dp_fn(simd_op, simd_A, simd_B) : 68'h0;
        for (int s = 1; s < LAT; s++) dp_pipe[s] <= dp_pipe[s-1];
    end
    assign simd_res = dp_pipe[LAT-1];

    task automatic chk(string name, logic [67:0] act, logic [67:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        int          port;
        int          tag;
        logic [67:0] data;
        int          due;
    } ent_t;

    ent_t        m_fifo[$];
    ent_t        m_fly[$];
    int          m_last = NREQ-1;
    logic        m_en   = 1'b0;
    logic [12:0] m_op   = '0;
    logic [67:0] m_A    = '0;
    logic [67:0] m_B    = '0;
    int          mc     = 0;

    always @(negedge clk) begin
        int              g;
        logic [NREQ-1:0] exp_rdy;
        g = -1;
        if (!rst && !flush && (m_fifo.size() + m_fly.size()) < DEPTH) begin
`ifdef SIMD_ARB_RR_EN
            for (int k = 1; k <= NREQ; k++)
                if (g < 0 && req_vld[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
`else
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && req_vld[k]) g = k;
`endif
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("m_req_rdy", 68'(req_rdy), 68'(exp_rdy));
        chk("m_simd_en", 68'(simd_en), 68'(m_en));
        chk("m_simd_op", 68'(simd_op), 68'(m_op));
        chk("m_simd_A", simd_A, m_A);
        chk("m_simd_B", simd_B, m_B);
        chk("m_res_vld", 68'(res_vld), 68'(m_fifo.size() > 0));
        if (m_fifo.size() > 0) begin
            chk("m_res_port", 68'(res_port), 68'(m_fifo[0].port));
            chk("m_res_tag", 68'(res_tag), 68'(m_fifo[0].tag));
            chk("m_res_data", res_data, m_fifo[0].data);
        end
        if (rst) begin
            m_fifo.delete(); m_fly.delete();
            m_last = NREQ-1; m_en = 1'b0; m_op = '0; m_A = '0; m_B = '0;
        end else if (flush) begin
            m_fifo.delete(); m_fly.delete();
            m_en = 1'b0;
        end else begin
            if (m_fifo.size() > 0 && res_rdy) void'(m_fifo.pop_front());
            m_en = (g >= 0);
            if (g >= 0) begin
                m_op = req_op[g]; m_A = req_A[g]; m_B = req_B[g]; m_last = g;
                m_fly.push_back('{port: g, tag: int'(req_tag[g]),
                                  data: dp_fn(req_op[g], req_A[g], req_B[g]), due: mc + LAT + 2});
            end
            while (m_fly.size() > 0 && m_fly[0].due == mc + 1) m_fifo.push_back(m_fly.pop_front());
        end
        mc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; req_vld = '0; res_rdy = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic set_port(int p, logic [12:0] op, logic [67:0] a, logic [67:0] b, logic [TAG_W-1:0] tag);
        req_op[p] = op; req_A[p] = a; req_B[p] = b; req_tag[p] = tag;
    endtask

    task automatic drain(int n);
        req_vld = '0; res_rdy = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    int gl[$];
    int acc;
    int exp_g;

    initial begin
        // reset state and single op on port 1
        do_reset();
        chk("rst_simd_en", 68'(simd_en), 68'd0);
        chk("rst_simd_op", 68'(simd_op), 68'd0);
        chk("rst_res_vld", 68'(res_vld), 68'd0);
        chk("rst_res_data", res_data, 68'd0);
        res_rdy = 1'b1;
        set_port(1, 13'h0a5, 68'h1_0000_0000_0000_0001, 68'h2_0000_0000_0000_0010, 9'h005);
        req_vld = 3'b010;
        settle();
        chk("s1_rdy_c0", 68'(req_rdy), 68'(3'b010));
        step(); req_vld = '0; settle();
        chk("s1_en_c1", 68'(simd_en), 68'd1);
        chk("s1_op_c1", 68'(simd_op), 68'h0a5);
        step(); settle(); chk("s1_vld_c2", 68'(res_vld), 68'd0);
        step(); settle(); chk("s1_vld_c3", 68'(res_vld), 68'd0);
        step(); settle();
        chk("s1_vld_c4", 68'(res_vld), 68'd1);
        chk("s1_port_c4", 68'(res_port), 68'd1);
        chk("s1_tag_c4", 68'(res_tag), 68'h005);
        chk("s1_data_c4", res_data, 68'h3_0000_0000_0000_00b4);
        step(); settle(); chk("s1_vld_c5", 68'(res_vld), 68'd0);
        drain(3);

        // all ports requesting continuously
        do_reset(); res_rdy = 1'b1;
        for (int p = 0; p < NREQ; p++) set_port(p, 13'(p + 1), 68'(p * 16 + 3), 68'd100, 9'(32 + p));
        req_vld = 3'b111;
        gl.delete();
        for (int c = 0; c < 12; c++) begin
            settle();
            for (int p = 0; p < NREQ; p++) if (req_rdy[p]) gl.push_back(p);
            step();
        end
        for (int n = 0; n < 6; n++) begin
`ifdef SIMD_ARB_RR_EN
            exp_g = n % NREQ;
`else
            exp_g = 0;
`endif
            chk($sformatf("s2_grant%0d", n), (gl.size() > n) ? 68'(gl[n]) : '1, 68'(exp_g));
        end
        drain(8);

        // backpressure with port 0 streaming
        do_reset(); res_rdy = 1'b0; acc = 0;
        req_vld = 3'b001;
        for (int c = 0; c < 10; c++) begin
            set_port(0, 13'h1f0, 68'hF_0000_0000_0000_0000 + 68'(c), 68'd5, 9'(64 + c));
            settle();
            if (req_rdy[0]) acc++;
            step();
        end
        chk("s3_accepts", 68'(acc), 68'd4);
        res_rdy = 1'b1; settle();
        chk("s3_rdy_c10", 68'(req_rdy), 68'd0);
        chk("s3_head_tag_c10", 68'(res_tag), 68'h040);
        step(); settle();
        chk("s3_rdy_c11", 68'(req_rdy), 68'(3'b001));
        for (int c = 11; c < 25; c++) begin
            set_port(0, 13'(c), 68'(c * 7), 68'(c), 9'(64 + c));
            step();
            if (c == 17) res_rdy = 1'b0;
            if (c == 20) res_rdy = 1'b1;
        end
        drain(10); settle();
        chk("s3_drained", 68'(res_vld), 68'd0);

        // flush kills two in-flight ops
        do_reset(); res_rdy = 1'b1;
        set_port(2, 13'h001, 68'h100, 68'h200, 9'h011); req_vld = 3'b100; step();
        set_port(0, 13'h002, 68'h300, 68'h400, 9'h012); req_vld = 3'b001; step();
        flush = 1'b1; settle();
        chk("s5_rdy_flush", 68'(req_rdy), 68'd0);
        step(); flush = 1'b0;
        set_port(1, 13'h003, 68'h10, 68'h20, 9'h013); req_vld = 3'b010; settle();
        chk("s5_rdy_c3", 68'(req_rdy), 68'(3'b010));
        step(); req_vld = '0;
        for (int c = 4; c < 7; c++) begin
            settle(); chk($sformatf("s5_vld_c%0d", c), 68'(res_vld), 68'd0); step();
        end
        settle();
        chk("s5_vld_c7", 68'(res_vld), 68'd1);
        chk("s5_tag_c7", 68'(res_tag), 68'h013);
        chk("s5_data_c7", res_data, 68'h33);
        step(); settle();
        chk("s5_vld_c8", 68'(res_vld), 68'd0);

        // flush while a result is waiting
        do_reset(); res_rdy = 1'b0;
        set_port(0, 13'h000, 68'h7, 68'h8, 9'h0ee); req_vld = 3'b001; step();
        req_vld = '0; step(); step(); step(); settle();
        chk("s5b_vld_before", 68'(res_vld), 68'd1);
        flush = 1'b1; res_rdy = 1'b1; step(); flush = 1'b0;
        req_vld = 3'b001; settle();
        chk("s5b_vld_after", 68'(res_vld), 68'd0);
        chk("s5b_rdy_after", 68'(req_rdy), 68'(3'b001));
        drain(8);

        // reset mid-stream
        do_reset(); res_rdy = 1'b0;
        for (int p = 0; p < NREQ; p++) set_port(p, 13'(p + 8), 68'(p + 1), 68'h55, 9'(80 + p));
        req_vld = 3'b111;
        step(); step(); step(); step();
        rst = 1'b1; settle();
        chk("s6_rdy_in_rst", 68'(req_rdy), 68'd0);
        step(); settle();
        chk("s6_simd_en", 68'(simd_en), 68'd0);
        chk("s6_simd_op", 68'(simd_op), 68'd0);
        chk("s6_simd_A", simd_A, 68'd0);
        chk("s6_simd_B", simd_B, 68'd0);
        chk("s6_res_vld", 68'(res_vld), 68'd0);
        chk("s6_res_port", 68'(res_port), 68'd0);
        chk("s6_res_tag", 68'(res_tag), 68'd0);
        chk("s6_res_data", res_data, 68'd0);
        rst = 1'b0; req_vld = 3'b111; settle();
        chk("s6_first_grant", 68'(req_rdy), 68'(3'b001));
        step();
        drain(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
